vga_timing_gen: RTL

- Generates VGA 640x480@60 raster timing: pixel_x/pixel_y counters, hsync/vsync, video_on.
- Drives the coordinate inputs of the on-screen overlay/text readers.
- Accepts their 12-bit RGB result back and gates it to the DAC pins.
- Delays sync/blank by the overlay pipeline latency so colour and sync stay pixel-aligned.

---
 rtl/vga_timing_pkg.sv | 33 +++
 rtl/sync_delay_line.sv | 36 +++
 rtl/vga_timing_gen.sv | 139 +++++++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants: default 640x480@60 geometry, sync polarity
// encoding and the colour-bar palette used by the built-in test pattern.
package vga_timing_pkg;

    localparam int VGA_H_DISPLAY = 640;
    localparam int VGA_H_FRONT   = 16;
    localparam int VGA_H_SYNC    = 96;
    localparam int VGA_H_BACK    = 48;
    localparam int VGA_V_DISPLAY = 480;
    localparam int VGA_V_FRONT   = 10;
    localparam int VGA_V_SYNC    = 2;
    localparam int VGA_V_BACK    = 33;

    localparam int VGA_H_TOTAL = VGA_H_DISPLAY + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
    localparam int VGA_V_TOTAL = VGA_V_DISPLAY + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

    // Level a sync pin takes while the pulse is active.
    typedef enum logic {
        SYNC_ACTIVE_LOW  = 1'b0,
        SYNC_ACTIVE_HIGH = 1'b1
    } sync_pol_e;

    // Eight vertical bars, left to right.
    localparam logic [11:0] BAR_COLOURS [8] = '{
        12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
        12'hF0F, 12'hF00, 12'h00F, 12'h000
    };

    function automatic logic [11:0] bar_colour(input logic [2:0] idx);
        return BAR_COLOURS[idx];
    endfunction

endpackage

// File: rtl/sync_delay_line.sv
// Fixed-depth shift register with synchronous reset to RST_VAL.
// DEPTH = 0 degenerates to a plain wire.
module sync_delay_line #(
    parameter int               WIDTH   = 1,
    parameter int               DEPTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_wire
            logic unused_ctl;
            assign unused_ctl = clk ^ reset;
            assign dout       = din;
        end else begin : g_shift
            logic [WIDTH-1:0] stage [DEPTH];

            // Shift one stage per clk; reset clears every stage.
            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
                end else begin
                    stage[0] <= din;
                    for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
                end
            end

            assign dout = stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator. Counters drive the overlay readers undelayed;
// blank/sync are delayed by PIPE_LAT clks plus one output register so they
// line up with the colour coming back on rgb_in.
// Optional build macro VGA_TEST_PATTERN_EN: replaces rgb_in with an internal
// 8-bar colour pattern aligned exactly like the external path.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int   H_DISPLAY = VGA_H_DISPLAY,
    parameter int   H_FRONT   = VGA_H_FRONT,
    parameter int   H_SYNC    = VGA_H_SYNC,
    parameter int   H_BACK    = VGA_H_BACK,
    parameter int   V_DISPLAY = VGA_V_DISPLAY,
    parameter int   V_FRONT   = VGA_V_FRONT,
    parameter int   V_SYNC    = VGA_V_SYNC,
    parameter int   V_BACK    = VGA_V_BACK,
    parameter int   CLK_DIV   = 4,
    parameter int   PIPE_LAT  = 3,
    parameter logic SYNC_POL  = SYNC_ACTIVE_LOW
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] rgb_in,
    output logic [9:0]  pixel_x,
    output logic [9:0]  pixel_y,
    output logic        pixel_tick,
    output logic        frame_start,
    output logic        video_on,
    output logic        hsync,
    output logic        vsync,
    output logic [11:0] rgb_out
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
    localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
    localparam logic [9:0] HS_START = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] HS_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] VS_END   = 10'(V_DISPLAY + V_FRONT + V_SYNC);

    logic [3:0]  div_cnt;
    logic [9:0]  h_cnt;
    logic [9:0]  v_cnt;
    logic        vis, hs, vs;
    logic [2:0]  flags_d;
    logic [11:0] colour_src;

    assign pixel_tick = (div_cnt == DIV_LAST);
    assign pixel_x    = h_cnt;
    assign pixel_y    = v_cnt;

    // Pixel-rate divider: free-runs 0..CLK_DIV-1.
    always_ff @(posedge clk) begin
        if (reset || pixel_tick) div_cnt <= 4'd0;
        else                     div_cnt <= div_cnt + 4'd1;
    end

    // Raster position: h advances per pixel, v advances on each h wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            h_cnt <= 10'd0;
            v_cnt <= 10'd0;
        end else if (pixel_tick) begin
            if (h_cnt == H_LAST) begin
                h_cnt <= 10'd0;
                v_cnt <= (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
            end else begin
                h_cnt <= h_cnt + 10'd1;
            end
        end
    end

    // First clk of pixel (0,0) is the only clk with all three counters at zero;
    // reset gating makes the clk right after reset release the pulse.
    assign frame_start = !reset && (div_cnt == 4'd0) && (h_cnt == 10'd0) && (v_cnt == 10'd0);

    assign vis = (h_cnt < H_VIS) && (v_cnt < V_VIS);
    assign hs  = (h_cnt >= HS_START) && (h_cnt < HS_END);
    assign vs  = (v_cnt >= VS_START) && (v_cnt < VS_END);

    sync_delay_line #(
        .WIDTH  (3),
        .DEPTH  (PIPE_LAT),
        .RST_VAL(3'b000)
    ) u_flag_dly (
        .clk  (clk),
        .reset(reset),
        .din  ({vis, hs, vs}),
        .dout (flags_d)
    );

`ifdef VGA_TEST_PATTERN_EN
    localparam logic [9:0] BAR_W = 10'(H_DISPLAY / 8);

    logic [9:0]  bar_idx_full;
    logic [11:0] bar_raw;
    logic        unused_pattern;

    // Columns past the last bar are blanked, so only the low 3 bits matter.
    assign bar_idx_full   = h_cnt / BAR_W;
    assign bar_raw        = bar_colour(bar_idx_full[2:0]);
    assign unused_pattern = ^{rgb_in, bar_idx_full[9:3]};

    sync_delay_line #(
        .WIDTH  (12),
        .DEPTH  (PIPE_LAT),
        .RST_VAL(12'h000)
    ) u_bar_dly (
        .clk  (clk),
        .reset(reset),
        .din  (bar_raw),
        .dout (colour_src)
    );
`else
    assign colour_src = rgb_in;
`endif

    // Output stage: blank-gate the colour and apply sync polarity.
    always_ff @(posedge clk) begin
        if (reset) begin
            rgb_out  <= 12'h000;
            video_on <= 1'b0;
            hsync    <= ~SYNC_POL;
            vsync    <= ~SYNC_POL;
        end else begin
            rgb_out  <= flags_d[2] ? colour_src : 12'h000;
            video_on <= flags_d[2];
            hsync    <= ~(flags_d[1] ^ SYNC_POL);
            vsync    <= ~(flags_d[0] ^ SYNC_POL);
        end
    end

endmodule
